// File: rtl/if_inst_queue_pkg.sv
// Shared pipeline definitions for the fetch-to-decode instruction queue.
package if_inst_queue_pkg;

    localparam int          DEFAULT_DATA_W = 32;
    localparam int          DEFAULT_PC_W   = 32;
    localparam logic [31:0] NOP_INST       = 32'h0000_0000;

endpackage

// File: rtl/if_inst_queue_mem.sv
// Entry storage for the instruction queue: synchronous write, asynchronous read.
module inst_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // No reset: stale entries are never visible while the queue is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/if_inst_queue.sv
// DEPTH-entry instruction/PC FIFO between instruction SRAM and ID, with
// optional empty-queue bypass, flush, almost-full throttle and sticky overflow flag.
module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int PC_W      = DEFAULT_PC_W,
    parameter int BYPASS    = 1,
    parameter int AF_MARGIN = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_inst,
    output logic [PC_W-1:0]            out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       err_overflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - AF_MARGIN);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             err_overflow_q, err_overflow_d;

    logic                   empty, full;
    logic                   push, bypass_take, wr_en, rd_en;
    logic [DATA_W+PC_W-1:0] rd_data;

    inst_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + PC_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_ptr_q[IDX_W-1:0]),
        .wr_data ({in_inst, in_pc}),
        .rd_idx  (rd_ptr_q[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        empty    = (rd_ptr_q == wr_ptr_q);
        full     = (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]) &&
                   (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);
        in_ready = !full;

        if (!empty) begin
            out_valid = !flush;
            out_inst  = rd_data[DATA_W+PC_W-1:PC_W];
            out_pc    = rd_data[PC_W-1:0];
        end else if (BYPASS != 0) begin
            out_valid = in_valid && !flush;
            out_inst  = in_inst;
            out_pc    = in_pc;
        end else begin
            out_valid = 1'b0;
            out_inst  = DATA_W'(NOP_INST);
            out_pc    = '0;
        end
        // Pointers are already cleared during reset; only the bypass path needs masking.
        out_valid = out_valid && resetn;

        push        = in_valid && in_ready && !flush;
        bypass_take = (BYPASS != 0) && empty && push && out_ready;
        wr_en       = push && !bypass_take;
        rd_en       = !empty && out_valid && out_ready;
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        err_overflow_d = err_overflow_q || (in_valid && !in_ready && !flush);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + PTR_W'(1);
                2'b01:   count_d = count_q - PTR_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_THRESH);
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_if_inst_queue.sv
// Self-checking bench for if_inst_queue: directed table, corner-case sequences
// and a randomized run against a queue-based reference model.
module tb_if_inst_queue;

    logic        clk = 1'b0;
    logic        resetn;
    // BYPASS=1 instance
    logic        flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready, out_valid, almost_full, err_overflow;
    logic [31:0] out_inst, out_pc;
    logic [2:0]  count;
    // BYPASS=0 instance
    logic        flush0, in_valid0, out_ready0;
    logic [31:0] in_inst0, in_pc0;
    logic        in_ready0, out_valid0, almost_full0, err_overflow0;
    logic [31:0] out_inst0, out_pc0;
    logic [2:0]  count0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_inst_queue #(.DEPTH(4), .DATA_W(32), .PC_W(32), .BYPASS(1), .AF_MARGIN(1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
        .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ready(out_ready), .count(count), .almost_full(almost_full),
        .err_overflow(err_overflow)
    );

    if_inst_queue #(.DEPTH(4), .DATA_W(32), .PC_W(32), .BYPASS(0), .AF_MARGIN(1)) dut0 (
        .clk(clk), .resetn(resetn), .flush(flush0), .in_valid(in_valid0),
        .in_inst(in_inst0), .in_pc(in_pc0), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_inst(out_inst0), .out_pc(out_pc0),
        .out_ready(out_ready0), .count(count0), .almost_full(almost_full0),
        .err_overflow(err_overflow0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        in_valid;
        logic [31:0] inst;
        logic        out_ready;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [2:0]  exp_count;
        logic        exp_in_ready;
        logic        exp_af;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    // Reference model state
    logic [63:0] model_q[$];
    logic        model_err;

    initial begin
        resetn = 1'b0;
        flush = 0; in_valid = 0; out_ready = 0; in_inst = 0; in_pc = 0;
        flush0 = 0; in_valid0 = 0; out_ready0 = 0; in_inst0 = 0; in_pc0 = 0;

        // ---- reset state ----
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_err", 64'(err_overflow), 64'd0);
        $display("reset: out_valid=%0d in_ready=%0d count=%0d", out_valid, in_ready, count);
        #10 resetn = 1'b1;
        tick();

        // ---- same-cycle bypass ----
        in_valid = 1; in_inst = 32'h2408_0005; in_pc = 32'hBFC0_0000; out_ready = 1;
        #1;
        check("byp_valid", 64'(out_valid), 64'd1);
        check("byp_inst", 64'(out_inst), 64'h2408_0005);
        check("byp_pc", 64'(out_pc), 64'hBFC0_0000);
        $display("bypass: inst=0x%08h pc=0x%08h valid=%0d", out_inst, out_pc, out_valid);
        tick();
        in_valid = 0;
        #1;
        check("byp_count", 64'(count), 64'd0);
        check("byp_empty_valid", 64'(out_valid), 64'd0);
        tick();

        // ---- fill / overflow / drain table ----
        vecs[0] = '{1, 32'h1111_0001, 0, 1, 32'h1111_0001, 0, 1, 0, 0};
        vecs[1] = '{1, 32'h1111_0002, 0, 1, 32'h1111_0001, 1, 1, 0, 0};
        vecs[2] = '{1, 32'h1111_0003, 0, 1, 32'h1111_0001, 2, 1, 0, 0};
        vecs[3] = '{1, 32'h1111_0004, 0, 1, 32'h1111_0001, 3, 1, 1, 0};
        vecs[4] = '{1, 32'h1111_0005, 0, 1, 32'h1111_0001, 4, 0, 1, 0};
        vecs[5] = '{0, 32'h0000_0000, 1, 1, 32'h1111_0001, 4, 0, 1, 1};
        vecs[6] = '{0, 32'h0000_0000, 1, 1, 32'h1111_0002, 3, 1, 1, 1};
        vecs[7] = '{0, 32'h0000_0000, 1, 1, 32'h1111_0003, 2, 1, 0, 1};
        vecs[8] = '{0, 32'h0000_0000, 1, 1, 32'h1111_0004, 1, 1, 0, 1};
        vecs[9] = '{0, 32'h0000_0000, 1, 0, 32'h0000_0000, 0, 1, 0, 1};
        for (int i = 0; i < 10; i++) begin
            in_valid = vecs[i].in_valid; in_inst = vecs[i].inst;
            in_pc = vecs[i].inst ^ 32'hFFFF_0000; out_ready = vecs[i].out_ready;
            #1;
            check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("tbl%0d_inst", i), 64'(out_inst), 64'(vecs[i].exp_inst));
            check($sformatf("tbl%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
            check($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
            check($sformatf("tbl%0d_af", i), 64'(almost_full), 64'(vecs[i].exp_af));
            check($sformatf("tbl%0d_err", i), 64'(err_overflow), 64'(vecs[i].exp_err));
            $display("row %0d: in_valid=%0d out_ready=%0d -> out_valid=%0d inst=0x%08h count=%0d af=%0d err=%0d",
                     i, in_valid, out_ready, out_valid, out_inst, count, almost_full, err_overflow);
            tick();
        end

        // ---- flush with simultaneous input at count=3 ----
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_inst = 32'h3300_0000 + 32'(i); in_pc = 32'(i);
            tick();
        end
        flush = 1; in_valid = 1; in_inst = 32'h3300_00FF; out_ready = 1;
        #1;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_pre_count", 64'(count), 64'd3);
        tick();
        flush = 0; in_valid = 0; out_ready = 0;
        #1;
        check("flush_count", 64'(count), 64'd0);
        check("flush_post_valid", 64'(out_valid), 64'd0);
        check("flush_err_kept", 64'(err_overflow), 64'd1);
        $display("flush: count=%0d out_valid=%0d err=%0d", count, out_valid, err_overflow);

        // ---- steady push+pop at count=2 across pointer wrap ----
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_inst = 32'hA000_0000 + 32'(i); in_pc = 32'(i);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_inst = 32'hA000_0000 + 32'(i + 2); in_pc = 32'(i + 2); out_ready = 1;
            #1;
            check($sformatf("pp%0d_inst", i), 64'(out_inst), 64'(32'hA000_0000 + 32'(i)));
            check($sformatf("pp%0d_count", i), 64'(count), 64'd2);
            $display("pushpop %0d: out=0x%08h count=%0d", i, out_inst, count);
            tick();
        end
        in_valid = 0; out_ready = 1;

        // ---- asynchronous reset mid-cycle with count=2 ----
        #2;
        resetn = 0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_err", 64'(err_overflow), 64'd0);
        $display("async reset: out_valid=%0d count=%0d err=%0d", out_valid, count, err_overflow);
        #3 resetn = 1;
        out_ready = 0;
        tick();

        // ---- BYPASS=0 latency ----
        check("nb_empty_inst", 64'(out_inst0), 64'd0);
        in_valid0 = 1; in_inst0 = 32'h0000_1021; in_pc0 = 32'h0000_0400; out_ready0 = 1;
        #1;
        check("nb_push_valid", 64'(out_valid0), 64'd0);
        check("nb_push_inst", 64'(out_inst0), 64'd0);
        tick();
        in_valid0 = 0;
        #1;
        check("nb_next_valid", 64'(out_valid0), 64'd1);
        check("nb_next_inst", 64'(out_inst0), 64'h0000_1021);
        check("nb_next_pc", 64'(out_pc0), 64'h0000_0400);
        $display("nobypass: out_valid=%0d inst=0x%08h", out_valid0, out_inst0);
        tick();
        #1;
        check("nb_after_valid", 64'(out_valid0), 64'd0);
        check("nb_after_count", 64'(count0), 64'd0);
        out_ready0 = 0;

        // ---- randomized run against reference model ----
        model_q.delete();
        model_err = 0;
        for (int c = 0; c < 300; c++) begin
            logic        e_valid, e_full, pop_m, push_m;
            logic [63:0] e_head;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(1) == 1);
            flush     = ($urandom_range(15) == 0);
            in_inst   = $urandom;
            in_pc     = $urandom;
            e_full = (model_q.size() == 4);
            if (flush) begin
                e_valid = 0; e_head = '0;
            end else if (model_q.size() != 0) begin
                e_valid = 1; e_head = model_q[0];
            end else begin
                e_valid = in_valid; e_head = {in_inst, in_pc};
            end
            #1;
            check($sformatf("rnd%0d_valid", c), 64'(out_valid), 64'(e_valid));
            if (e_valid) check($sformatf("rnd%0d_data", c), {out_inst, out_pc}, e_head);
            check($sformatf("rnd%0d_count", c), 64'(count), 64'(model_q.size()));
            check($sformatf("rnd%0d_in_ready", c), 64'(in_ready), 64'(!e_full));
            check($sformatf("rnd%0d_af", c), 64'(almost_full), 64'(model_q.size() >= 3));
            check($sformatf("rnd%0d_err", c), 64'(err_overflow), 64'(model_err));
            $display("rnd %0d: iv=%0d or=%0d fl=%0d out_valid=%0d inst=0x%08h count=%0d",
                     c, in_valid, out_ready, flush, out_valid, out_inst, count);
            if (flush) begin
                model_q.delete();
            end else begin
                if (in_valid && e_full) model_err = 1;
                pop_m  = e_valid && out_ready;
                push_m = in_valid && !e_full;
                if (!(model_q.size() == 0 && push_m && pop_m)) begin
                    if (pop_m) void'(model_q.pop_front());
                    if (push_m) model_q.push_back({in_inst, in_pc});
                end
            end
            tick();
        end
        flush = 0; in_valid = 0; out_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
